wavetable_voice_scheduler: RTL and testbench

- Time-multiplexes the single-port, 256x9 wavetable ROM between NUM_VOICES oscillator voices.
- Per voice: holds a phase accumulator and a phase increment (frequency).
- On each sample_tick it issues one table address per voice, captures the returned levels (ROM has 1-cycle registered latency) and sums them into one mixed sample.
- Sits between the sample-rate timer and the DAC/PWM output stage.

---
 rtl/wavetable_voice_scheduler.sv | 159 +++++++++++++++
 tb/tb_wavetable_voice_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wavetable_voice_scheduler.sv
// wavetable_voice_scheduler
// Shares one 256x9 wavetable ROM among NUM_VOICES phase-accumulator voices.
// On sample_tick it issues one table address per voice on consecutive cycles,
// accumulates the returned levels and presents the mixed sample on mix_out.
// Optional build macro: WAVETABLE_MIX_AVG_EN (mix_out carries sum >> VOICE_BITS).
module wavetable_voice_scheduler #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned VOICE_BITS = 2,
  parameter int unsigned PHASE_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_tick,
  input  logic                    inc_we,
  input  logic [VOICE_BITS-1:0]   inc_sel,
  input  logic [PHASE_W-1:0]      inc_data,
  input  logic [NUM_VOICES-1:0]   voice_en,
  input  logic                    overrun_clr,
  output logic [7:0]              table_pos,
  input  logic [8:0]              table_level,
  output logic [8+VOICE_BITS:0]   mix_out,
  output logic                    mix_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned MIX_W = 9 + VOICE_BITS;
  localparam logic [VOICE_BITS-1:0] LAST_V = VOICE_BITS'(NUM_VOICES - 1);
  localparam logic [VOICE_BITS-1:0] ONE_V  = VOICE_BITS'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, LAST, DONE} state_e;

  state_e                  state_q, state_d;
  logic [VOICE_BITS-1:0]   cnt_q, cnt_d;
  logic [MIX_W-1:0]        acc_q, acc_d;
  logic [MIX_W-1:0]        mix_q, mix_d;
  logic [7:0]              pos_q, pos_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    ovr_q, ovr_d;
  logic [PHASE_W-1:0]      phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]      phase_d [NUM_VOICES];
  logic [PHASE_W-1:0]      inc_q   [NUM_VOICES];
  logic [PHASE_W-1:0]      inc_d   [NUM_VOICES];

  logic                    issue_en;
  logic [VOICE_BITS-1:0]   issue_v;
  logic [MIX_W-1:0]        level_k;
  logic [MIX_W-1:0]        acc_sum;

  // Next-state, issue/capture datapath, phase and increment updates.
  // cnt_q names the voice being captured this edge; the voice issued is cnt_q+1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mix_d    = mix_q;
    pos_d    = pos_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    ovr_d    = ovr_q & ~overrun_clr;
    phase_d  = phase_q;
    inc_d    = inc_q;
    issue_en = 1'b0;
    issue_v  = '0;
    level_k  = voice_en[cnt_q] ? MIX_W'(table_level) : '0;
    acc_sum  = acc_q + level_k;

    if (inc_we) begin
      inc_d[inc_sel] = inc_data;
    end

    case (state_q)
      IDLE, DONE: begin
        valid_d = 1'b0;
        state_d = IDLE;
        if (sample_tick) begin
          state_d  = ISSUE;
          busy_d   = 1'b1;
          cnt_d    = '0;
          acc_d    = '0;
          issue_en = 1'b1;
          issue_v  = '0;
        end
      end
      ISSUE: begin
        if (sample_tick) begin
          ovr_d = 1'b1;
        end
        acc_d    = acc_sum;
        issue_en = 1'b1;
        issue_v  = cnt_q + ONE_V;
        cnt_d    = cnt_q + ONE_V;
        if (cnt_q + ONE_V == LAST_V) begin
          state_d = LAST;
        end
      end
      LAST: begin
        if (sample_tick) begin
          ovr_d = 1'b1;
        end
`ifdef WAVETABLE_MIX_AVG_EN
        mix_d = MIX_W'(acc_sum >> VOICE_BITS);
`else
        mix_d = acc_sum;
`endif
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The issued voice reads its pre-update phase; its accumulator then
    // advances with the increment held before any write on this same edge.
    if (issue_en) begin
      pos_d = phase_q[issue_v][PHASE_W-1 -: 8];
      phase_d[issue_v] = voice_en[issue_v] ? phase_q[issue_v] + inc_q[issue_v] : '0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mix_q   <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mix_q   <= mix_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      phase_q <= phase_d;
      inc_q   <= inc_d;
    end
  end

  assign table_pos = pos_q;
  assign mix_out   = mix_q;
  assign mix_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// Self-checking bench for wavetable_voice_scheduler: behavioural ROM and a
// frame-level reference model of phases, increments and the mixed sample.
module tb_wavetable_voice_scheduler;

  localparam int NV = 4;
  localparam int VB = 2;
  localparam int MW = 9 + VB;

  logic          clk;
  logic          rst_n;
  logic          sample_tick;
  logic          inc_we;
  logic [VB-1:0] inc_sel;
  logic [15:0]   inc_data;
  logic [NV-1:0] voice_en;
  logic          overrun_clr;
  logic [7:0]    table_pos;
  logic [8:0]    table_level;
  logic [MW-1:0] mix_out;
  logic          mix_valid;
  logic          busy;
  logic          overrun;

  logic [8:0]    rom [256];
  logic [15:0]   m_phase [NV];
  logic [15:0]   m_inc   [NV];

  int n_checks;
  int n_fail;

  wavetable_voice_scheduler #(
    .NUM_VOICES(NV),
    .VOICE_BITS(VB),
    .PHASE_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_tick(sample_tick),
    .inc_we(inc_we),
    .inc_sel(inc_sel),
    .inc_data(inc_data),
    .voice_en(voice_en),
    .overrun_clr(overrun_clr),
    .table_pos(table_pos),
    .table_level(table_level),
    .mix_out(mix_out),
    .mix_valid(mix_valid),
    .busy(busy),
    .overrun(overrun)
  );

  assign table_level = rom[table_pos];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NV; k++) begin
      m_phase[k] = 16'h0;
      m_inc[k]   = 16'h0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic write_inc(input int v, input logic [15:0] d);
    inc_we   = 1'b1;
    inc_sel  = VB'(v);
    inc_data = d;
    step();
    inc_we   = 1'b0;
    m_inc[v] = d;
  endtask

  task automatic rom_ramp();
    for (int i = 0; i < 256; i++) rom[i] = 9'(i);
  endtask

  // One mix frame. ovr_j/race_j >= 1 inject a tick / an inc write on edge E0+j.
  task automatic run_frame(input bit chain, input int ovr_j, input bit clr_with_ovr,
                           input int race_j, input logic [15:0] race_data,
                           output logic [MW-1:0] got);
    logic [7:0]    exp_pos [NV];
    logic [MW-1:0] exp_mix;
    int            sum;
    sum = 0;
    for (int k = 0; k < NV; k++) begin
      exp_pos[k] = m_phase[k][15:8];
      if (voice_en[k]) sum += int'(rom[exp_pos[k]]);
      m_phase[k] = voice_en[k] ? m_phase[k] + m_inc[k] : 16'h0;
    end
`ifdef WAVETABLE_MIX_AVG_EN
    exp_mix = MW'(sum / NV);
`else
    exp_mix = MW'(sum);
`endif
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int j = 0; j < NV; j++) begin
      n_checks++;
      if (table_pos !== exp_pos[j] || busy !== 1'b1 || mix_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL frame_issue v%0d: pos=%0d busy=%b valid=%b, want pos=%0d busy=1 valid=0",
                 j, table_pos, busy, mix_valid, exp_pos[j]);
      end
      if (ovr_j == j + 1) begin
        sample_tick = 1'b1;
        overrun_clr = clr_with_ovr;
      end
      if (race_j == j + 1) begin
        inc_we   = 1'b1;
        inc_sel  = VB'(race_j);
        inc_data = race_data;
      end
      step();
      sample_tick = 1'b0;
      overrun_clr = 1'b0;
      inc_we      = 1'b0;
    end
    n_checks++;
    if (mix_valid !== 1'b1 || mix_out !== exp_mix || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_result: valid=%b mix=%0d busy=%b, want valid=1 mix=%0d busy=0",
               mix_valid, mix_out, busy, exp_mix);
    end
    got = mix_out;
    if (race_j > 0) m_inc[race_j] = race_data;
    if (!chain) begin
      step();
      n_checks++;
      if (mix_valid !== 1'b0 || mix_out !== exp_mix) begin
        n_fail++;
        $display("FAIL frame_after: valid=%b mix=%0d, want valid=0 mix=%0d held",
                 mix_valid, mix_out, exp_mix);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      sample_tick = 1'($urandom);
      inc_we      = 1'($urandom);
      inc_sel     = VB'($urandom);
      inc_data    = 16'($urandom);
      voice_en    = NV'($urandom);
      overrun_clr = 1'($urandom);
      step();
      n_checks++;
      if (table_pos !== 8'h0 || mix_out !== '0 || mix_valid !== 1'b0 ||
          busy !== 1'b0 || overrun !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: pos=%0d mix=%0d valid=%b busy=%b ovr=%b, want all 0",
                 table_pos, mix_out, mix_valid, busy, overrun);
      end
    end
    sample_tick = 1'b0;
    inc_we      = 1'b0;
    overrun_clr = 1'b0;
    voice_en    = '0;
    rst_n       = 1'b1;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (mix_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: valid=%b busy=%b, want 0 0", mix_valid, busy);
      end
    end
  endtask

  task automatic test_single_voice();
    logic [MW-1:0] got;
    apply_reset();
    rom_ramp();
    voice_en = 4'b0001;
    write_inc(0, 16'h0100);
    for (int f = 0; f < 257; f++) begin
      run_frame(1'b0, 0, 1'b0, 0, 16'h0, got);
      n_checks++;
      if (got !== MW'(f % 256)) begin
        n_fail++;
        $display("FAIL single_voice f%0d: mix=%0d, want %0d", f, got, f % 256);
      end
      step();
      step();
    end
  endtask

  task automatic test_four_voices();
    logic [MW-1:0] got;
    logic [MW-1:0] want [4];
    apply_reset();
    rom_ramp();
    for (int v = 0; v < NV; v++) write_inc(v, 16'((v + 1) * 256));
    want[0] = 0;
    want[1] = 10;
    want[2] = 12;
    want[3] = 3 + 6 + 9;
    for (int f = 0; f < 4; f++) begin
      voice_en = (f == 2) ? 4'b0111 : 4'b1111;
      run_frame(1'b0, 0, 1'b0, 0, 16'h0, got);
`ifdef WAVETABLE_MIX_AVG_EN
      want[f] = want[f] >> VB;
`endif
      n_checks++;
      if (got !== want[f]) begin
        n_fail++;
        $display("FAIL four_voices f%0d: mix=%0d, want %0d", f, got, want[f]);
      end
    end
  endtask

  task automatic test_overrun();
    logic [MW-1:0] got;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_initial: ovr=%b, want 0", overrun);
    end
    voice_en = 4'b1111;
    run_frame(1'b0, 2, 1'b0, 0, 16'h0, got);
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (overrun !== 1'b1 || mix_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL overrun_sticky: ovr=%b valid=%b busy=%b, want 1 0 0",
                 overrun, mix_valid, busy);
      end
    end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: ovr=%b, want 0", overrun);
    end
    run_frame(1'b0, 3, 1'b1, 0, 16'h0, got);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set_wins: ovr=%b, want 1", overrun);
    end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
  endtask

  task automatic test_full_scale();
    logic [MW-1:0] got;
    logic [MW-1:0] want;
    for (int i = 0; i < 256; i++) rom[i] = 9'h1FF;
    voice_en = 4'b1111;
`ifdef WAVETABLE_MIX_AVG_EN
    want = 11'd511;
`else
    want = 11'h7FC;
`endif
    run_frame(1'b0, 0, 1'b0, 0, 16'h0, got);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL full_scale: mix=%0d, want %0d", got, want);
    end
    rom_ramp();
  endtask

  task automatic test_midframe_reset();
    logic [MW-1:0] got;
    voice_en = 4'b1111;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (table_pos !== 8'h0 || mix_out !== '0 || mix_valid !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: pos=%0d mix=%0d valid=%b busy=%b ovr=%b, want all 0",
               table_pos, mix_out, mix_valid, busy, overrun);
    end
    step();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++;
      if (mix_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midframe_no_valid: valid=%b, want 0", mix_valid);
      end
    end
    run_frame(1'b0, 0, 1'b0, 0, 16'h0, got);
  endtask

  task automatic test_inc_race();
    logic [MW-1:0] got;
    logic [MW-1:0] want [3];
    apply_reset();
    rom_ramp();
    voice_en = 4'b1111;
    write_inc(1, 16'h0100);
    want[0] = 0;
    want[1] = 1;
    want[2] = 6;
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0, 0, 1'b0, (f == 0) ? 1 : 0, 16'h0500, got);
`ifdef WAVETABLE_MIX_AVG_EN
      want[f] = want[f] >> VB;
`endif
      n_checks++;
      if (got !== want[f]) begin
        n_fail++;
        $display("FAIL inc_race f%0d: mix=%0d, want %0d", f, got, want[f]);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [MW-1:0] got;
    bit chain;
    bit prev_chain;
    apply_reset();
    for (int i = 0; i < 256; i++) rom[i] = 9'($urandom_range(0, 511));
    prev_chain = 1'b0;
    for (int f = 0; f < 60; f++) begin
      if (!prev_chain) begin
        if ($urandom_range(0, 1) == 1) write_inc($urandom_range(0, NV - 1), 16'($urandom));
        for (int c = 0; c < $urandom_range(0, 2); c++) step();
      end
      voice_en = NV'($urandom);
      chain = 1'($urandom_range(0, 1));
      run_frame(chain, 0, 1'b0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, NV - 1) : 0,
                16'($urandom), got);
      prev_chain = chain;
    end
    if (prev_chain) step();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    inc_we      = 1'b0;
    inc_sel     = '0;
    inc_data    = '0;
    voice_en    = '0;
    overrun_clr = 1'b0;
    rom_ramp();
    model_reset();
    test_reset();
    test_single_voice();
    test_four_voices();
    test_overrun();
    test_full_scale();
    test_midframe_reset();
    test_inc_race();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
